sram_confreg_responder: RTL and testbench

- Responder (slave) end of the CPU's data SRAM interface (en / wen / addr / wdata / rdata).
- Contains:
  - a word-addressed, byte-writable RAM;
  - a memory-mapped configuration register region: LED, NUM, SWITCH and a free-running TIMER.
- Sits beside the CPU top in the SoC wrapper. Serves every load and store the pipeline issues, with a fixed one-cycle read latency.

---
 rtl/sram_confreg_responder_if.sv | 12 +
 rtl/sram_confreg_responder.sv | 111 +++++++++++
 tb/tb_sram_confreg_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sram_confreg_responder_if.sv
// Data SRAM bus between the CPU (master) and the memory/confreg responder (slave).
// rdata is registered by the slave and valid the cycle after a read request.
interface sram_confreg_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_confreg_responder.sv
// Slave end of the CPU data SRAM bus: byte-writable word RAM plus the LED/NUM/SWITCH/TIMER
// configuration registers, one-cycle registered read latency.
module sram_confreg_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
    input  logic                         clk,
    input  logic                         resetn,
    sram_confreg_responder_if.slave      bus,
    input  logic [7:0]                   switch,
    output logic [15:0]                  led,
    output logic [31:0]                  num_data
);
    localparam logic [15:0] OFF_LED    = 16'h8000;
    localparam logic [15:0] OFF_NUM    = 16'h8010;
    localparam logic [15:0] OFF_SWITCH = 16'h8020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [31:0]       rdata_reg;
    logic [15:0]       led_reg;
    logic [31:0]       num_reg;
    logic [31:0]       timer_reg;
    logic [7:0]        sw_meta_reg;
    logic [7:0]        sw_sync_reg;

    logic              conf_hit;
    logic              is_write;
    logic              is_read;
    logic              ram_we;
    logic              conf_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       conf_off;
    logic [31:0]       wmask;
    logic [31:0]       conf_rdata;

    assign conf_hit = ((bus.addr & CONF_MASK) == CONF_BASE);
    assign is_write = bus.en && (bus.wen != 4'b0000);
    assign is_read  = bus.en && (bus.wen == 4'b0000);
    assign ram_we   = is_write && !conf_hit;
    assign conf_we  = is_write && conf_hit;
    assign ram_idx  = bus.addr[RAM_AW+1:2];
    assign conf_off = bus.addr[15:0];

    // Expand the byte enables into a bit mask for the register lane merges.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[8*gi +: 8] = {8{bus.wen[gi]}};
        end
    endgenerate

    // RAM contents survive reset, but a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (resetn && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    mem[ram_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        conf_rdata = 32'h0;
        case (conf_off)
            OFF_LED:    conf_rdata = {16'h0, led_reg};
            OFF_NUM:    conf_rdata = num_reg;
            OFF_SWITCH: conf_rdata = {24'h0, sw_sync_reg};
            OFF_TIMER:  conf_rdata = timer_reg;
            default:    conf_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_reg <= 32'h0;
        end else if (is_read) begin
            rdata_reg <= conf_hit ? conf_rdata : mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_reg     <= 16'h0;
            num_reg     <= 32'h0;
            timer_reg   <= 32'h0;
            sw_meta_reg <= 8'h0;
            sw_sync_reg <= 8'h0;
        end else begin
            sw_meta_reg <= switch;
            sw_sync_reg <= sw_meta_reg;
            if (conf_we && conf_off == OFF_LED) begin
                led_reg <= (led_reg & ~wmask[15:0]) | (bus.wdata[15:0] & wmask[15:0]);
            end
            if (conf_we && conf_off == OFF_NUM) begin
                num_reg <= (num_reg & ~wmask) | (bus.wdata & wmask);
            end
            // A TIMER store replaces the count for that cycle instead of incrementing it.
            if (conf_we && conf_off == OFF_TIMER) begin
                timer_reg <= (timer_reg & ~wmask) | (bus.wdata & wmask);
            end else begin
                timer_reg <= timer_reg + 32'd1;
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign led       = led_reg;
    assign num_data  = num_reg;
endmodule

// File: tb/tb_sram_confreg_responder.sv
// Directed bench for sram_confreg_responder: reads queue their expected data, and a monitor
// compares rdata on the cycle after each read request it observes on the bus.
module tb_sram_confreg_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    sram_confreg_responder_if bus ();

    sram_confreg_responder dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .switch   (switch),
        .led      (led),
        .num_data (num_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_seen = 1'b0;

    localparam logic [31:0] A_LED    = 32'hbfaf_8000;
    localparam logic [31:0] A_NUM    = 32'hbfaf_8010;
    localparam logic [31:0] A_SWITCH = 32'hbfaf_8020;
    localparam logic [31:0] A_TIMER  = 32'hbfaf_e000;

    // Monitor: a read accepted at this edge must show its data by the following negedge.
    always @(posedge clk) rd_seen <= bus.en && (bus.wen == 4'b0000) && resetn;

    always @(negedge clk) begin
        if (rd_seen) begin
            logic [31:0] e;
            string       n;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read rdata=%h required=<none queued>", bus.rdata);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.rdata !== e) begin
                    errors++;
                    $display("FAIL %s rdata=%h required=%h", n, bus.rdata, e);
                end else begin
                    $display("read  %-16s rdata=%h", n, bus.rdata);
                end
            end
        end
    end

    task automatic op(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        #1;
        bus.en  = 1'b0;
        bus.wen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        op(1'b1, 4'b0000, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        op(1'b1, wen, addr, data);
        $display("write addr=%h wen=%b wdata=%h", addr, wen, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("check %-16s value=%h", name, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 1'b0; bus.wen = 4'b0000; bus.addr = 32'h0; bus.wdata = 32'h0;
        switch = 8'h00;

        // Reset then idle; first post-release edge takes TIMER 0->1, read sampled at the 5th edge sees 4.
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_num", num_data, 32'h0);
        idle(4);
        rd(A_TIMER, 32'd4, "timer_after_rst");

        // RAM byte writes; rdata holds the last read result across the writes.
        wr(32'h0000_0010, 4'hf, 32'h1122_3344);
        check("hold_wr1", bus.rdata, 32'd4);
        wr(32'h0000_0010, 4'b0010, 32'h0000_aa00);
        check("hold_wr2", bus.rdata, 32'd4);
        rd(32'h0000_0010, 32'h1122_aa44, "ram_byte_merge");
        // en=0 with wen set must not write; high bits alias onto the same word.
        op(1'b0, 4'hf, 32'h0000_0010, 32'h0);
        rd(32'h0040_0010, 32'h1122_aa44, "ram_alias_noen");

        // Configuration registers.
        wr(A_LED, 4'hf, 32'hdead_beef);
        check("led_port", {16'h0, led}, 32'h0000_beef);
        rd(A_LED, 32'h0000_beef, "led_read");
        wr(A_NUM, 4'hf, 32'h1234_5678);
        check("num_port", num_data, 32'h1234_5678);
        rd(A_NUM, 32'h1234_5678, "num_read");

        // TIMER write priority and wrap, back-to-back reads.
        wr(A_TIMER, 4'hf, 32'hffff_fffe);
        rd(A_TIMER, 32'hffff_fffe, "timer_fffe");
        rd(A_TIMER, 32'hffff_ffff, "timer_ffff");
        rd(A_TIMER, 32'h0000_0000, "timer_wrap");
        wr(A_TIMER, 4'hf, 32'h0000_1200);
        wr(A_TIMER, 4'b0001, 32'h0000_0055);
        rd(A_TIMER, 32'h0000_1255, "timer_partial");

        // Switch synchronizer, unmapped offset, read-only SWITCH.
        switch = 8'ha5;
        idle(2);
        rd(A_SWITCH, 32'h0000_00a5, "switch_sync");
        rd(32'hbfaf_4000, 32'h0, "unmapped");
        wr(A_SWITCH, 4'hf, 32'hffff_ffff);
        rd(A_SWITCH, 32'h0000_00a5, "switch_ro");
        check("led_after_swwr", {16'h0, led}, 32'h0000_beef);
        check("num_after_swwr", num_data, 32'h1234_5678);

        // Reset arriving together with a RAM write.
        wr(32'h0000_0020, 4'hf, 32'h0bad_0bad);
        resetn = 1'b0;
        wr(32'h0000_0020, 4'hf, 32'hcafe_f00d);
        resetn = 1'b1;
        check("rst2_rdata", bus.rdata, 32'h0);
        check("rst2_led", {16'h0, led}, 32'h0);
        check("rst2_num", num_data, 32'h0);
        rd(A_TIMER, 32'h0, "rst2_timer");
        rd(32'h0000_0020, 32'h0bad_0bad, "rst2_ram_kept");
        rd(A_LED, 32'h0, "rst2_led_read");
        rd(A_NUM, 32'h0, "rst2_num_read");

        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
